// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave oven sequencer.
// State encoding is visible on state_o, so the values are fixed.
package microwave_pkg;

  localparam int BCD_W  = 4;
  localparam int TIME_W = 4 * BCD_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/microwave_ctrl_if.sv
// Button, keypad, door and display/actuator signals of the oven sequencer.
// master drives the buttons (panel/testbench), slave is the controller.
interface microwave_ctrl_if;

  logic                             startn;
  logic                             stopn;
  logic                             clearn;
  logic                             door_closed;
  logic                             key_valid;
  logic [microwave_pkg::BCD_W-1:0]  key_digit;
  logic                             mag_on;
  logic                             timer_done;
  logic                             beep;
  logic [microwave_pkg::TIME_W-1:0] time_bcd;
  logic [2:0]                       state_o;

  modport master (
    output startn, stopn, clearn, door_closed, key_valid, key_digit,
    input  mag_on, timer_done, beep, time_bcd, state_o
  );

  modport slave (
    input  startn, stopn, clearn, door_closed, key_valid, key_digit,
    output mag_on, timer_done, beep, time_bcd, state_o
  );

endinterface

// File: rtl/bcd_mmss_down.sv
// MM:SS BCD time register: clear, load, keypad shift-in and one-second decrement.
// Seconds wrap to 59 on borrow; minutes wrap to 99.
module bcd_mmss_down
  import microwave_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [TIME_W-1:0] load_val_i,
  input  logic              shift_i,
  input  logic [BCD_W-1:0]  digit_i,
  input  logic              dec_i,
  output logic [TIME_W-1:0] time_o,
  output logic              is_zero_o,
  output logic              is_one_o
);

  // Per-digit value taken after a borrow: {m1,m0,s1,s0}
  localparam logic [TIME_W-1:0] WRAP_BCD = 16'h9959;

  logic [TIME_W-1:0] time_q;
  logic [TIME_W-1:0] time_d;
  logic [TIME_W-1:0] dec_val;
  logic [3:0]        borrow;

  assign borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [BCD_W-1:0] d;
      assign d = time_q[gi*BCD_W +: BCD_W];
      assign dec_val[gi*BCD_W +: BCD_W] =
          !borrow[gi]  ? d :
          (d == '0)    ? WRAP_BCD[gi*BCD_W +: BCD_W] :
                         d - BCD_W'(1);
      if (gi < 3) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] & (d == '0);
      end
    end
  endgenerate

  always_comb begin
    time_d = time_q;
    if (clr_i) begin
      time_d = '0;
    end else if (load_i) begin
      time_d = load_val_i;
    end else if (dec_i) begin
      time_d = dec_val;
    end else if (shift_i) begin
      time_d = {time_q[TIME_W-BCD_W-1:0], digit_i};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      time_q <= '0;
    end else begin
      time_q <= time_d;
    end
  end

  assign time_o    = time_q;
  assign is_zero_o = (time_q == '0);
  assign is_one_o  = (time_q == TIME_W'(1));

endmodule

// File: rtl/microwave_ctrl.sv
// Oven sequencer: keypad entry, 1 Hz BCD countdown, magnetron enable and buzzer timing.
// One FSM arbitrates buttons, door and tick in a fixed per-cycle priority.
module microwave_ctrl
  import microwave_pkg::*;
#(
  parameter int                CLK_HZ          = 50_000_000,
  parameter logic [TIME_W-1:0] QUICK_START_BCD = 16'h0030,
  parameter int                BEEP_SEC        = 3
) (
  input  logic              clk,
  input  logic              resetn,
  microwave_ctrl_if.slave   mw
);

  localparam int            PW        = cnt_width(CLK_HZ);
  localparam int            BW        = cnt_width(BEEP_SEC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BEEP_MAX  = BW'(BEEP_SEC - 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [BW-1:0]     beep_cnt_q, beep_cnt_d;
  logic              timer_done_q, timer_done_d;
  logic              beep_q;

  logic              clr, load, shift, dec;
  logic [TIME_W-1:0] time_bcd;
  logic              is_zero, is_one;
  logic              counting, tick, key_ok, shifted_nz, any_button;

  bcd_mmss_down u_time (
    .clk        (clk),
    .resetn     (resetn),
    .clr_i      (clr),
    .load_i     (load),
    .load_val_i (QUICK_START_BCD),
    .shift_i    (shift),
    .digit_i    (mw.key_digit),
    .dec_i      (dec),
    .time_o     (time_bcd),
    .is_zero_o  (is_zero),
    .is_one_o   (is_one)
  );

  assign counting   = (state_q == ST_COOK) || (state_q == ST_DONE);
  assign tick       = counting && (presc_q == PRESC_MAX);
  assign key_ok     = mw.key_valid && (mw.key_digit <= BCD_W'(9));
  assign shifted_nz = (time_bcd[TIME_W-BCD_W-1:0] != '0) || (mw.key_digit != '0);
  assign any_button = mw.startn || mw.stopn || mw.clearn;

  always_comb begin
    state_d      = state_q;
    clr          = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;
    dec          = 1'b0;
    timer_done_d = 1'b0;
    beep_cnt_d   = beep_cnt_q;
    presc_d      = '0;

    case (state_q)
      ST_IDLE, ST_SET: begin
        if (mw.clearn) begin
          clr     = 1'b1;
          state_d = ST_IDLE;
        end else if (!mw.stopn) begin
          // Start with the door open falls through so a key in the same cycle still lands.
          if (mw.startn && mw.door_closed) begin
            load    = is_zero;
            state_d = ST_COOK;
          end else if (key_ok) begin
            shift   = 1'b1;
            state_d = shifted_nz ? ST_SET : ST_IDLE;
          end
        end
      end
      ST_COOK: begin
        if (mw.clearn) begin
          clr     = 1'b1;
          state_d = ST_IDLE;
        end else if (mw.stopn || !mw.door_closed) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          dec = 1'b1;
          if (is_one) begin
            timer_done_d = 1'b1;
            state_d      = ST_DONE;
          end
        end
      end
      ST_PAUSE: begin
        if (mw.clearn || mw.stopn) begin
          clr     = 1'b1;
          state_d = ST_IDLE;
        end else if (mw.startn && mw.door_closed) begin
          state_d = ST_COOK;
        end
      end
      ST_DONE: begin
        if (any_button || !mw.door_closed) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (beep_cnt_q == BEEP_MAX) begin
            state_d = ST_IDLE;
          end else begin
            beep_cnt_d = beep_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every state change restarts the second and the beep count.
    if (state_d != state_q) begin
      beep_cnt_d = '0;
    end else if (counting && !tick) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      beep_cnt_q   <= '0;
      timer_done_q <= 1'b0;
      beep_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      beep_cnt_q   <= beep_cnt_d;
      timer_done_q <= timer_done_d;
      beep_q       <= (state_d == ST_DONE);
    end
  end

  // Combinational so an opening door cuts the magnetron without waiting for a clock.
  assign mw.mag_on     = (state_q == ST_COOK) && mw.door_closed;
  assign mw.timer_done = timer_done_q;
  assign mw.beep       = beep_q;
  assign mw.time_bcd   = time_bcd;
  assign mw.state_o    = state_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed and random stimulus for microwave_ctrl, checked every cycle against a
// behavioural oven model that keeps time as plain minutes and seconds.
module tb_microwave_ctrl;

  localparam int CLK_HZ   = 4;
  localparam int BEEP_SEC = 2;
  localparam int S_IDLE = 0, S_SET = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic door = 1'b1;

  microwave_ctrl_if mw ();

  microwave_ctrl #(
    .CLK_HZ          (CLK_HZ),
    .QUICK_START_BCD (16'h0030),
    .BEEP_SEC        (BEEP_SEC)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .mw     (mw)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_seen = 0;

  // Reference model state
  int m_st = S_IDLE;
  int m_min = 0;
  int m_sec = 0;
  int m_age = 0;
  int m_beeps = 0;
  bit m_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_time();
    return 32'(((m_min / 10) << 12) | ((m_min % 10) << 8) | ((m_sec / 10) << 4) | (m_sec % 10));
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_min = 0; m_sec = 0; m_age = 0; m_beeps = 0; m_done = 1'b0;
  endtask

  task automatic model_update(input bit st, input bit sp, input bit cl, input bit kv, input int kd);
    int  nst;
    bit  tick;
    nst    = m_st;
    tick   = (m_st == S_COOK || m_st == S_DONE) && (m_age % CLK_HZ == CLK_HZ - 1);
    m_done = 1'b0;
    case (m_st)
      S_IDLE, S_SET: begin
        if (cl) begin
          m_min = 0; m_sec = 0; nst = S_IDLE;
        end else if (sp) begin
          nst = m_st;
        end else if (st && door) begin
          if (m_min == 0 && m_sec == 0) m_sec = 30;
          nst = S_COOK;
        end else if (kv && kd <= 9) begin
          m_min = (m_min % 10) * 10 + m_sec / 10;
          m_sec = (m_sec % 10) * 10 + kd;
          nst   = (m_min != 0 || m_sec != 0) ? S_SET : S_IDLE;
        end
      end
      S_COOK: begin
        if (cl) begin
          m_min = 0; m_sec = 0; nst = S_IDLE;
        end else if (sp || !door) begin
          nst = S_PAUSE;
        end else if (tick) begin
          if (m_min == 0 && m_sec == 1) begin
            m_sec = 0; m_done = 1'b1; nst = S_DONE;
          end else if (m_sec > 0) begin
            m_sec--;
          end else begin
            m_sec = 59; m_min--;
          end
        end
      end
      S_PAUSE: begin
        if (cl || sp) begin
          m_min = 0; m_sec = 0; nst = S_IDLE;
        end else if (st && door) begin
          nst = S_COOK;
        end
      end
      default: begin
        if (st || sp || cl || !door) begin
          nst = S_IDLE;
        end else if (tick) begin
          m_beeps++;
          if (m_beeps == BEEP_SEC) nst = S_IDLE;
        end
      end
    endcase
    if (nst != m_st) begin
      m_age = 0; m_beeps = 0;
    end else begin
      m_age++;
    end
    m_st = nst;
  endtask

  // One clock of stimulus, entered and left on a falling edge.
  task automatic step(input bit st, input bit sp, input bit cl, input bit kv, input logic [3:0] kd);
    mw.startn = st; mw.stopn = sp; mw.clearn = cl;
    mw.key_valid = kv; mw.key_digit = kd; mw.door_closed = door;
    #1;
    chk("mag_on", 32'(mw.mag_on), 32'(m_st == S_COOK && door));
    model_update(st, sp, cl, kv, int'(kd));
    @(posedge clk);
    @(negedge clk);
    mw.startn = 1'b0; mw.stopn = 1'b0; mw.clearn = 1'b0; mw.key_valid = 1'b0;
    chk("time_bcd", 32'(mw.time_bcd), exp_time());
    chk("state_o", 32'(mw.state_o), 32'(m_st));
    chk("beep", 32'(mw.beep), 32'(m_st == S_DONE));
    chk("timer_done", 32'(mw.timer_done), 32'(m_done));
    if (mw.timer_done) done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b0, 1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic start();
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic stop();
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic clear();
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    mw.startn = 1'b0; mw.stopn = 1'b0; mw.clearn = 1'b0;
    mw.key_valid = 1'b0; mw.key_digit = 4'd0; mw.door_closed = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(mw.state_o), 32'(S_IDLE));
    chk("reset_time", 32'(mw.time_bcd), 32'h0);
    chk("reset_outs", 32'({mw.mag_on, mw.beep, mw.timer_done}), 32'h0);
    resetn = 1'b1;
    model_reset();

    // Entry 01:05 then a full cook and beep
    key(4'd1); key(4'd0); key(4'd5);
    chk("entry_0105", 32'(mw.time_bcd), 32'h0105);
    start();
    chk("cook_mag_on", 32'(mw.mag_on), 32'h1);
    done_seen = 0;
    idle(65 * CLK_HZ + BEEP_SEC * CLK_HZ + 4);
    chk("done_once", 32'(done_seen), 32'h1);
    chk("after_beep", 32'(mw.state_o), 32'(S_IDLE));

    // Borrows from 01:00 and 00:90
    key(4'd1); key(4'd0); key(4'd0); start(); idle(CLK_HZ);
    chk("borrow_0059", 32'(mw.time_bcd), 32'h0059);
    clear();
    key(4'd9); key(4'd0); start(); idle(CLK_HZ);
    chk("borrow_0089", 32'(mw.time_bcd), 32'h0089);
    clear();

    // Door opens mid-cook at 00:20, then resume
    key(4'd2); key(4'd0); start();
    door = 1'b0; idle(3);
    chk("door_pause", 32'(mw.state_o), 32'(S_PAUSE));
    chk("door_frozen", 32'(mw.time_bcd), 32'h0020);
    door = 1'b1; start(); idle(CLK_HZ);
    chk("resume_0019", 32'(mw.time_bcd), 32'h0019);
    clear();

    // Quick start, and start with door open in SET
    start();
    chk("quick_0030", 32'(mw.time_bcd), 32'h0030);
    clear();
    key(4'd5); door = 1'b0; start();
    chk("open_start_set", 32'(mw.state_o), 32'(S_SET));
    door = 1'b1; clear();

    // Clear+start in PAUSE, stop in PAUSE, keys during COOK
    key(4'd1); key(4'd0); start(); idle(2); stop();
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("clr_start_pause", 32'(mw.time_bcd), 32'h0);
    key(4'd2); start(); stop(); stop();
    chk("stop_pause", 32'(mw.state_o), 32'(S_IDLE));
    key(4'd3); start(); key(4'd7);
    chk("cook_key_ignored", 32'(mw.time_bcd), 32'h0003);

    // Asynchronous reset mid-cook
    resetn = 1'b0;
    #1;
    chk("async_mag_on", 32'(mw.mag_on), 32'h0);
    chk("async_time", 32'(mw.time_bcd), 32'h0);
    chk("async_outs", 32'({mw.beep, mw.timer_done, mw.state_o}), 32'h0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    key(4'd3); key(4'hA);
    chk("key_a_ignored", 32'(mw.time_bcd), 32'h0003);
    clear();

    // Random traffic, one event per cycle
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 3) door = ~door;
      r = int'($urandom_range(0, 99));
      if (r < 5)       start();
      else if (r < 8)  stop();
      else if (r < 10) clear();
      else if (r < 40) key(4'($urandom_range(0, 15)));
      else             idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
